step_motor_sequencer: RTL and testbench

- Sequences one bipolar stepper channel: AX/AY/BX/BY coil drive plus AE/BE bridge enables, as routed to the PIO26 header pins.
- Accepts move commands (direction, step count, step period) over a valid/ready handshake and emits the coil phase pattern at the commanded rate.
- After a move, it either holds torque or de-energizes the coils.
- Four instances sit beside the top-level pin mux, one per step_motor_N, with command registers driven from the bus-side register file.

---
 rtl/step_motor_sequencer.sv | 165 ++++++++++++++++
 tb/tb_step_motor_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/step_motor_sequencer.sv
// rtl/step_motor_sequencer.sv - bipolar stepper phase sequencer; STEP_MOTOR_HALF_STEP_EN selects the 8-entry half-step table
module step_motor_sequencer #(
  parameter int STEP_W       = 16,
  parameter int PERIOD_W     = 20,
  parameter bit HOLD_DEFAULT = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [STEP_W-1:0]   cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                cmd_hold,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [STEP_W-1:0]   steps_remaining,
  output logic                AX,
  output logic                AY,
  output logic                BX,
  output logic                BY,
  output logic                AE,
  output logic                BE
);

`ifdef STEP_MOTOR_HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic                dir_q, dir_d;
  logic                hold_q, hold_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                done_q, done_d;
  logic [5:0]          drive_q, drive_d;
  logic [PERIOD_W-1:0] period_clamped;

  // Coil pattern {AX, AY, BX, BY, AE, BE} for a phase index
  function automatic logic [5:0] phase_pattern(input logic [PH_W-1:0] idx);
    logic [5:0] pat;
`ifdef STEP_MOTOR_HALF_STEP_EN
    case (idx)
      3'd0:    pat = 6'b101011;
      3'd1:    pat = 6'b001001;
      3'd2:    pat = 6'b011011;
      3'd3:    pat = 6'b010010;
      3'd4:    pat = 6'b010111;
      3'd5:    pat = 6'b000101;
      3'd6:    pat = 6'b100111;
      default: pat = 6'b100010;
    endcase
`else
    case (idx)
      2'd0:    pat = 6'b101011;
      2'd1:    pat = 6'b011011;
      2'd2:    pat = 6'b010111;
      default: pat = 6'b100111;
    endcase
`endif
    return pat;
  endfunction

  assign period_clamped  = (cmd_period < PERIOD_W'(2)) ? PERIOD_W'(2) : cmd_period;
  // Abort in IDLE/HOLD drops a simultaneous command, so ready falls with abort
  assign cmd_ready       = (state_q != RUN) && !abort;
  assign busy            = (state_q == RUN);
  assign done            = done_q;
  assign steps_remaining = steps_q;
  assign {AX, AY, BX, BY, AE, BE} = drive_q;

  // State and datapath registers; reset clears the drive immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      dir_q    <= 1'b0;
      hold_q   <= HOLD_DEFAULT;
      period_q <= PERIOD_W'(2);
      cnt_q    <= '0;
      steps_q  <= '0;
      done_q   <= 1'b0;
      drive_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      hold_q   <= hold_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      done_q   <= done_d;
      drive_q  <= drive_d;
    end
  end

  // Next-state, step timing and registered coil drive
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    dir_d    = dir_q;
    hold_d   = hold_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    steps_d  = steps_q;
    done_d   = 1'b0;
    drive_d  = drive_q;

    case (state_q)
      RUN: begin
        if (abort) begin
          done_d  = 1'b1;
          state_d = hold_q ? HOLD : IDLE;
          drive_d = hold_q ? drive_q : 6'd0;
        end else if (cnt_q == '0) begin
          cnt_d   = period_q - PERIOD_W'(1);
          phase_d = dir_q ? (phase_q + PH_W'(1)) : (phase_q - PH_W'(1));
          steps_d = steps_q - STEP_W'(1);
          // The final phase is shown for one cycle even when de-energizing afterwards
          drive_d = phase_pattern(phase_d);
          if (steps_q == STEP_W'(1)) begin
            done_d  = 1'b1;
            state_d = hold_q ? HOLD : IDLE;
          end
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end

      default: begin
        drive_d = (state_q == HOLD) ? phase_pattern(phase_q) : 6'd0;
        if (abort) begin
          state_d = IDLE;
          drive_d = 6'd0;
        end else if (cmd_valid) begin
          dir_d    = cmd_dir;
          hold_d   = cmd_hold;
          period_d = period_clamped;
          cnt_d    = period_clamped - PERIOD_W'(1);
          steps_d  = cmd_steps;
          if (cmd_steps == '0) begin
            done_d  = 1'b1;
            state_d = cmd_hold ? HOLD : IDLE;
            drive_d = cmd_hold ? phase_pattern(phase_q) : 6'd0;
          end else begin
            state_d = RUN;
            drive_d = phase_pattern(phase_q);
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_step_motor_sequencer.sv
// tb/tb_step_motor_sequencer.sv - randomized and directed bench for step_motor_sequencer against a timeline model
module tb_step_motor_sequencer;

  localparam int STEP_W   = 16;
  localparam int PERIOD_W = 20;
`ifdef STEP_MOTOR_HALF_STEP_EN
  localparam int NPH = 8;
`else
  localparam int NPH = 4;
`endif

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_dir = 1'b0;
  logic [STEP_W-1:0]   cmd_steps = '0;
  logic [PERIOD_W-1:0] cmd_period = '0;
  logic                cmd_hold = 1'b0;
  logic                abort = 1'b0;
  logic                busy;
  logic                done;
  logic [STEP_W-1:0]   steps_remaining;
  logic                AX, AY, BX, BY, AE, BE;
  logic [5:0]          drive_obs;

  step_motor_sequencer #(
    .STEP_W(STEP_W),
    .PERIOD_W(PERIOD_W),
    .HOLD_DEFAULT(1'b0)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps),
    .cmd_period(cmd_period),
    .cmd_hold(cmd_hold),
    .abort(abort),
    .busy(busy),
    .done(done),
    .steps_remaining(steps_remaining),
    .AX(AX),
    .AY(AY),
    .BX(BX),
    .BY(BY),
    .AE(AE),
    .BE(BE)
  );

  assign drive_obs = {AX, AY, BX, BY, AE, BE};

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [5:0] tbl [8];

  // Reference: a move is a timeline anchored at its accept edge
  bit m_moving, m_done, m_fin, m_hold_st, m_hold, m_dir;
  int m_phase, m_start, m_t0, m_per, m_steps, m_rem;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_moving = 0; m_done = 0; m_fin = 0; m_hold_st = 0; m_hold = 0; m_dir = 0;
    m_phase = 0; m_start = 0; m_t0 = 0; m_per = 2; m_steps = 0; m_rem = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [5:0] exp_drive;
    exp_drive = (m_moving || m_fin || m_hold_st) ? tbl[m_phase] : 6'd0;
    check_eq({tag, ":drive"}, 32'(drive_obs), 32'(exp_drive));
    check_eq({tag, ":busy"}, 32'(busy), 32'(m_moving));
    check_eq({tag, ":done"}, 32'(done), 32'(m_done));
    check_eq({tag, ":rem"}, 32'(steps_remaining), 32'(m_rem));
    check_eq({tag, ":ready"}, 32'(cmd_ready), 32'(!m_moving && !abort));
  endtask

  task automatic tick(input string tag);
    int k;
    @(posedge clock);
    #1;
    cyc++;
    m_done = 0;
    m_fin  = 0;
    if (m_moving) begin
      if (abort) begin
        m_moving  = 0;
        m_done    = 1;
        m_hold_st = m_hold;
      end else if ((cyc - m_t0) % m_per == 0) begin
        k = (cyc - m_t0) / m_per;
        m_phase = m_dir ? (m_start + k) % NPH : (((m_start - k) % NPH) + NPH) % NPH;
        m_rem = m_steps - k;
        if (k == m_steps) begin
          m_moving  = 0;
          m_done    = 1;
          m_fin     = 1;
          m_hold_st = m_hold;
        end
      end
    end else begin
      if (abort) begin
        m_hold_st = 0;
      end else if (cmd_valid) begin
        m_t0    = cyc;
        m_per   = (cmd_period < 2) ? 2 : int'(cmd_period);
        m_steps = int'(cmd_steps);
        m_dir   = cmd_dir;
        m_hold  = cmd_hold;
        m_start = m_phase;
        m_rem   = int'(cmd_steps);
        if (cmd_steps == 0) begin
          m_done    = 1;
          m_hold_st = cmd_hold;
        end else begin
          m_moving = 1;
        end
      end
    end
    check_outputs(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic issue(input bit dir, input int steps, input int period, input bit hold, input string tag);
    cmd_dir    = dir;
    cmd_steps  = STEP_W'(steps);
    cmd_period = PERIOD_W'(period);
    cmd_hold   = hold;
    cmd_valid  = 1'b1;
    tick(tag);
    cmd_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    model_reset();
    check_outputs("reset");
  endtask

  initial begin
    tbl[0] = 6'b101011;
`ifdef STEP_MOTOR_HALF_STEP_EN
    tbl[1] = 6'b001001; tbl[2] = 6'b011011; tbl[3] = 6'b010010;
    tbl[4] = 6'b010111; tbl[5] = 6'b000101; tbl[6] = 6'b100111; tbl[7] = 6'b100010;
`else
    tbl[1] = 6'b011011; tbl[2] = 6'b010111; tbl[3] = 6'b100111;
    tbl[4] = 6'b000000; tbl[5] = 6'b000000; tbl[6] = 6'b000000; tbl[7] = 6'b000000;
`endif
    model_reset();
    do_reset();

    // Forward 5 steps, period 4, no hold
    issue(1'b1, 5, 4, 1'b0, "fwd5");
    run(19, "fwd5");
    tick("fwd5_end");
    check_eq("fwd5_done_at_20", 32'(done), 32'd1);
    tick("fwd5_idle");
    check_eq("fwd5_deenergized", 32'(drive_obs), 32'd0);

    // Reverse 3 steps from index 0 with hold
    do_reset();
    issue(1'b0, 3, 10, 1'b1, "rev3");
    run(32, "rev3");
`ifndef STEP_MOTOR_HALF_STEP_EN
    check_eq("rev3_hold_pattern", 32'(drive_obs), 32'(6'b011011));
`endif
    check_eq("rev3_ready", 32'(cmd_ready), 32'd1);

    // Abort 25 clocks into a 10-step move
    issue(1'b1, 10, 10, 1'b0, "abort");
    run(24, "abort");
    abort = 1'b1;
    tick("abort_edge");
    abort = 1'b0;
    check_eq("abort_rem8", 32'(steps_remaining), 32'd8);
    check_eq("abort_busy0", 32'(busy), 32'd0);
    run(3, "abort_after");

    // Zero-step command and period clamp
    issue(1'b1, 0, 7, 1'b1, "zero");
    run(2, "zero");
    issue(1'b1, 3, 0, 1'b0, "clamp");
    run(2, "clamp");
    check_eq("clamp_step1_at_2", 32'(steps_remaining), 32'd2);
    run(6, "clamp");

    // Accept and abort together in IDLE: command dropped
    cmd_valid = 1'b1; cmd_steps = 16'd4; cmd_period = 20'd3; abort = 1'b1;
    tick("drop");
    cmd_valid = 1'b0; abort = 1'b0;
    check_eq("drop_not_busy", 32'(busy), 32'd0);

    // Asynchronous reset between edges mid-move
    issue(1'b1, 10, 3, 1'b1, "async");
    run(7, "async");
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_drive0", 32'(drive_obs), 32'd0);
    check_eq("async_busy0", 32'(busy), 32'd0);
    check_eq("async_rem0", 32'(steps_remaining), 32'd0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    model_reset();
    #1;
    check_eq("async_ready1", 32'(cmd_ready), 32'd1);

    // Randomized commands, aborts and overlaps
    for (int i = 0; i < 900; i++) begin
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_dir    = 1'($urandom_range(0, 1));
      cmd_steps  = STEP_W'($urandom_range(0, 6));
      cmd_period = PERIOD_W'($urandom_range(0, 5));
      cmd_hold   = 1'($urandom_range(0, 1));
      abort      = ($urandom_range(0, 29) == 0);
      tick("rand");
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    run(40, "drain");

`ifdef STEP_MOTOR_HALF_STEP_EN
    // Full half-step revolution
    do_reset();
    issue(1'b1, 8, 2, 1'b0, "half");
    run(2, "half");
    check_eq("half_idx1", 32'(drive_obs), 32'(6'b001001));
    run(14, "half");
    check_eq("half_back_to_0", 32'(drive_obs), 32'(6'b101011));
    run(2, "half_idle");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
